sdram_byte_reader: RTL

// - Read-back counterpart of the ROM/cart-RAM byte loader. Reads a byte range from SDRAM over one

---
 rtl/sdram_byte_reader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_byte_reader.sv
// Streams a byte range read from SDRAM over a toggle req/ack port, big-endian, valid/ready out; SDRAM_BYTE_READER_PREFETCH_EN adds a second word buffer.
// Latency: first toggle 2 cycles after start, first byte 2 cycles after the word is acked; done 2 cycles after the last accept.
// Backpressure: out_do/out_valid hold until out_ready; a new word is only requested once the current one is consumed or prefetched.
module sdram_byte_reader #(
  parameter int ADDR_W = 21,
  parameter int LEN_W  = 23
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W:0]   base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:1]   mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_dout,
  output logic [7:0]        out_do,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cur_q, cur_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [15:0]       buf_q, buf_d;
  logic [ADDR_W:1]   mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic [7:0]        out_do_q, out_do_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_match, accept;
  logic [ADDR_W:0]   cur_inc;
`ifdef SDRAM_BYTE_READER_PREFETCH_EN
  logic [15:0]       pf_buf_q, pf_buf_d;
  logic              pf_vld_q, pf_vld_d;
  logic              pf_pend_q, pf_pend_d;
  logic [15:0]       pf_word;
`endif

  assign ack_match = (mem_ack == mem_req_q);
  assign accept    = out_valid_q & out_ready;
  assign cur_inc   = cur_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    buf_d       = buf_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = mem_req_q;
    out_do_d    = out_do_q;
    out_valid_d = out_valid_q;
    done_d      = (state_q == S_FIN);
`ifdef SDRAM_BYTE_READER_PREFETCH_EN
    pf_buf_d    = pf_buf_q;
    pf_vld_d    = pf_vld_q;
    pf_pend_d   = pf_pend_q;
    pf_word     = pf_vld_q ? pf_buf_q : mem_dout;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && ack_match) begin
          cur_d   = base;
          rem_d   = len;
          state_d = (len == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        mem_addr_d = cur_q[ADDR_W:1];
        mem_req_d  = ~mem_req_q;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (ack_match) begin
          buf_d   = mem_dout;
          state_d = S_DRAIN;
`ifdef SDRAM_BYTE_READER_PREFETCH_EN
          pf_pend_d = 1'b0;
          // Prefetch only when bytes remain beyond this word, so the last word never over-reads.
          if (cur_q[0] ? (rem_q > LEN_W'(1)) : (rem_q > LEN_W'(2))) begin
            mem_addr_d = cur_q[ADDR_W:1] + 1'b1;
            mem_req_d  = ~mem_req_q;
            pf_pend_d  = 1'b1;
          end
`endif
        end
      end
      S_DRAIN: begin
`ifdef SDRAM_BYTE_READER_PREFETCH_EN
        if (pf_pend_q && ack_match) begin
          pf_buf_d  = mem_dout;
          pf_vld_d  = 1'b1;
          pf_pend_d = 1'b0;
        end
`endif
        if (!out_valid_q) begin
          out_do_d    = cur_q[0] ? buf_q[7:0] : buf_q[15:8];
          out_valid_d = 1'b1;
        end else if (accept) begin
          cur_d = cur_inc;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            out_valid_d = 1'b0;
            state_d     = S_FIN;
          end else if (cur_q[0]) begin
`ifdef SDRAM_BYTE_READER_PREFETCH_EN
            // Word boundary: switch straight to the prefetched word, even if it arrives this cycle.
            if (pf_vld_q || (pf_pend_q && ack_match)) begin
              buf_d     = pf_word;
              out_do_d  = pf_word[15:8];
              pf_vld_d  = 1'b0;
              pf_pend_d = 1'b0;
              if (rem_q > LEN_W'(3)) begin
                mem_addr_d = cur_inc[ADDR_W:1] + 1'b1;
                mem_req_d  = ~mem_req_q;
                pf_pend_d  = 1'b1;
              end
            end else begin
              out_valid_d = 1'b0;
              state_d     = S_WAIT;
            end
`else
            out_valid_d = 1'b0;
            state_d     = S_REQ;
`endif
          end else begin
            out_do_d = buf_q[7:0];
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      buf_q       <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      out_do_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SDRAM_BYTE_READER_PREFETCH_EN
      pf_buf_q    <= '0;
      pf_vld_q    <= 1'b0;
      pf_pend_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      buf_q       <= buf_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      out_do_q    <= out_do_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SDRAM_BYTE_READER_PREFETCH_EN
      pf_buf_q    <= pf_buf_d;
      pf_vld_q    <= pf_vld_d;
      pf_pend_q   <= pf_pend_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_req   = mem_req_q;
  assign out_do    = out_do_q;
  assign out_valid = out_valid_q;

endmodule
